// File: rtl/keypad_if.sv
// Keypad pin and status bundle between the matrix scanner (master) and the
// board/bus side (slave).
interface keypad_if;
    logic [3:0]  iROW;
    logic [3:0]  oCOL;
    logic [15:0] oKEYST;
    logic [7:0]  oKEYNUM;

    modport master (input iROW, output oCOL, oKEYST, oKEYNUM);
    modport slave  (output iROW, input oCOL, oKEYST, oKEYNUM);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column drive, row sampling, per-key debounce,
// lowest-key encoder. Define KEYPAD_DEBOUNCE_EN to enable per-key debounce.

// One key's state tracker. With a single-frame requirement there is nothing to
// filter, so the key just follows its raw sample.
module keypad_debounce #(
    parameter int DEB_FRAMES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sampleEn,
    input  logic raw,
    output logic keyState
);
    if (DEB_FRAMES <= 1) begin : gDirect
        always_ff @(posedge clk) begin
            if (rst)
                keyState <= 1'b0;
            else if (sampleEn)
                keyState <= raw;
        end
    end else begin : gDeb
        localparam int CW = $clog2(DEB_FRAMES);
        logic          lastRaw;
        logic [CW-1:0] cnt;

        // cnt counts repeats after the first differing sample, so the state
        // flips on the DEB_FRAMES-th identical sample.
        always_ff @(posedge clk) begin
            if (rst) begin
                keyState <= 1'b0;
                lastRaw  <= 1'b0;
                cnt      <= '0;
            end else if (sampleEn) begin
                lastRaw <= raw;
                if (raw == keyState || raw != lastRaw) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_FRAMES - 2)) begin
                    keyState <= raw;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

module keypad_scanner #(
    parameter int SCAN_DIV   = 5000,
    parameter int DEB_FRAMES = 3
) (
    input  logic     iclk,
    input  logic     inrest,
    keypad_if.master kp
);
    localparam int PW = $clog2(SCAN_DIV);
`ifdef KEYPAD_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int DEB_EFF = DEB_ON ? DEB_FRAMES : 1;

    logic [3:0]    rowMeta;
    logic [3:0]    rowSync;
    logic [PW-1:0] phaseCnt;
    logic [1:0]    col;
    logic          phaseEnd;
    logic [15:0]   keySt;
    logic [7:0]    nextNum;

    assign phaseEnd = (phaseCnt == PW'(SCAN_DIV - 1));

    always_ff @(posedge iclk) begin
        if (inrest) begin
            rowMeta  <= 4'hF;
            rowSync  <= 4'hF;
            phaseCnt <= '0;
            col      <= 2'd0;
            kp.oCOL  <= 4'b1110;
        end else begin
            rowMeta <= kp.iROW;
            rowSync <= rowMeta;
            if (phaseEnd) begin
                phaseCnt <= '0;
                col      <= col + 2'd1;
                kp.oCOL  <= ~(4'b0001 << (col + 2'd1));
            end else begin
                phaseCnt <= phaseCnt + 1'b1;
            end
        end
    end

    // Sampling happens on the last cycle of a phase, while the column is still driven.
    for (genvar k = 0; k < 16; k++) begin : gKey
        keypad_debounce #(.DEB_FRAMES(DEB_EFF)) uDeb (
            .clk      (iclk),
            .rst      (inrest),
            .sampleEn (phaseEnd && (col == 2'(k % 4))),
            .raw      (~rowSync[k / 4]),
            .keyState (keySt[k])
        );
    end

    assign kp.oKEYST = keySt;

    always_comb begin
        nextNum = 8'hFF;
        for (int k = 15; k >= 0; k--)
            if (keySt[k]) nextNum = 8'(k);
    end

    always_ff @(posedge iclk) begin
        if (inrest)
            kp.oKEYNUM <= 8'hFF;
        else
            kp.oKEYNUM <= nextNum;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner; a small keypad model turns the set of
// pressed keys into row levels according to the driven column.
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SD = 8;
    localparam int DF = 3;
    localparam int FR = 4 * SD;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int NF  = DF;
    localparam bit DEB = 1'b1;
`else
    localparam int NF  = 1;
    localparam bit DEB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] kmap = 16'h0;
    logic [3:0]  rowModel;
    int          n = 0;
    int          total = 0;
    int          bad = 0;

    keypad_if kif();

    keypad_scanner #(.SCAN_DIV(SD), .DEB_FRAMES(DF)) dut (
        .iclk   (clk),
        .inrest (rst),
        .kp     (kif.master)
    );

    always #5 clk = ~clk;

    always_comb begin
        rowModel = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kif.oCOL[c] && kmap[r*4+c]) rowModel[r] = 1'b0;
    end
    assign kif.iROW = rowModel;

    // Advance to edge t after reset release, then settle 1 ns past the edge.
    task automatic stepTo(input int t);
        while (n < t) begin
            @(posedge clk);
            n++;
        end
        #1;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        kmap = 16'h0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (kif.oCOL !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b exp=1110", kif.oCOL); end
        total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL reset_keyst got=%h exp=0000", kif.oKEYST); end
        total++; if (kif.oKEYNUM !== 8'hFF) begin bad++; $display("FAIL reset_keynum got=%h exp=ff", kif.oKEYNUM); end
        rst = 1'b0;
        n = 0;
        stepTo(SD - 1);
        total++; if (kif.oCOL !== 4'b1110) begin bad++; $display("FAIL first_phase_col got=%b exp=1110", kif.oCOL); end
        stepTo(SD);
        total++; if (kif.oCOL !== 4'b1101) begin bad++; $display("FAIL second_phase_col got=%b exp=1101", kif.oCOL); end
    endtask

    task automatic test_idle();
        logic [3:0] e;
        kmap = 16'h0;
        applyReset();
        for (int t = 1; t <= 10 * FR; t++) begin
            stepTo(t);
            e = 4'b1111;
            e[(t / SD) % 4] = 1'b0;
            total++; if (kif.oCOL !== e) begin bad++; $display("FAIL idle_col t=%0d got=%b exp=%b", t, kif.oCOL, e); end
            total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL idle_keyst t=%0d got=%h exp=0000", t, kif.oKEYST); end
            total++; if (kif.oKEYNUM !== 8'hFF) begin bad++; $display("FAIL idle_keynum t=%0d got=%h exp=ff", t, kif.oKEYNUM); end
        end
    endtask

    task automatic test_row_held();
        int setEdge;
        int lastEdge;
        kmap = 16'h0;
        applyReset();
        kmap = 16'h0F00;
        setEdge  = SD + FR * (NF - 1);
        lastEdge = 4 * SD + FR * (NF - 1);
        stepTo(setEdge - 1);
        total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL row2_early got=%h exp=0000", kif.oKEYST); end
        stepTo(setEdge);
        total++; if (kif.oKEYST !== 16'h0100) begin bad++; $display("FAIL row2_first got=%h exp=0100", kif.oKEYST); end
        total++; if (kif.oKEYNUM !== 8'hFF) begin bad++; $display("FAIL row2_num_lag got=%h exp=ff", kif.oKEYNUM); end
        stepTo(setEdge + 1);
        total++; if (kif.oKEYNUM !== 8'h08) begin bad++; $display("FAIL row2_num got=%h exp=08", kif.oKEYNUM); end
        stepTo(lastEdge + 1);
        total++; if (kif.oKEYST !== 16'h0F00) begin bad++; $display("FAIL row2_all got=%h exp=0f00", kif.oKEYST); end
        total++; if (kif.oKEYNUM !== 8'h08) begin bad++; $display("FAIL row2_all_num got=%h exp=08", kif.oKEYNUM); end
        stepTo(lastEdge + 1 + SD);
    endtask

    task automatic test_reset_mid();
        total++; if (kif.oKEYST !== 16'h0F00) begin bad++; $display("FAIL mid_pre_keyst got=%h exp=0f00", kif.oKEYST); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL mid_keyst got=%h exp=0000", kif.oKEYST); end
        total++; if (kif.oKEYNUM !== 8'hFF) begin bad++; $display("FAIL mid_keynum got=%h exp=ff", kif.oKEYNUM); end
        total++; if (kif.oCOL !== 4'b1110) begin bad++; $display("FAIL mid_col got=%b exp=1110", kif.oCOL); end
        kmap = 16'h0;
        rst  = 1'b0;
        n = 0;
    endtask

    task automatic test_single_key();
        int setEdge;
        int clrEdge;
        kmap = 16'h0;
        applyReset();
        kmap = 16'h0002;
        setEdge = 2 * SD + FR * (NF - 1);
        stepTo(setEdge - 1);
        total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL key1_early got=%h exp=0000", kif.oKEYST); end
        stepTo(setEdge);
        total++; if (kif.oKEYST !== 16'h0002) begin bad++; $display("FAIL key1_set got=%h exp=0002", kif.oKEYST); end
        stepTo(setEdge + 1);
        total++; if (kif.oKEYNUM !== 8'h01) begin bad++; $display("FAIL key1_num got=%h exp=01", kif.oKEYNUM); end
        kmap = 16'h0;
        clrEdge = setEdge + FR * NF;
        stepTo(clrEdge - 1);
        total++; if (kif.oKEYST !== 16'h0002) begin bad++; $display("FAIL key1_hold got=%h exp=0002", kif.oKEYST); end
        stepTo(clrEdge);
        total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL key1_release got=%h exp=0000", kif.oKEYST); end
        stepTo(clrEdge + 1);
        total++; if (kif.oKEYNUM !== 8'hFF) begin bad++; $display("FAIL key1_release_num got=%h exp=ff", kif.oKEYNUM); end
    endtask

    task automatic test_bounce();
        logic [15:0] e;
        int setEdge;
        kmap = 16'h0;
        applyReset();
        for (int f = 0; f < 6; f++) begin
            stepTo(FR * f + 1);
            kmap = (f % 2 == 0) ? 16'h0040 : 16'h0000;
            stepTo(FR * f + 3 * SD + 1);
            e = (!DEB && (f % 2 == 0)) ? 16'h0040 : 16'h0000;
            total++; if (kif.oKEYST !== e) begin bad++; $display("FAIL bounce f=%0d got=%h exp=%h", f, kif.oKEYST, e); end
        end
        stepTo(FR * 6 + 1);
        kmap = 16'h0040;
        setEdge = FR * 6 + 3 * SD + FR * (NF - 1);
        stepTo(setEdge - 1);
        total++; if (kif.oKEYST !== 16'h0) begin bad++; $display("FAIL bounce_stable_early got=%h exp=0000", kif.oKEYST); end
        stepTo(setEdge);
        total++; if (kif.oKEYST !== 16'h0040) begin bad++; $display("FAIL bounce_stable got=%h exp=0040", kif.oKEYST); end
        stepTo(setEdge + 1);
        total++; if (kif.oKEYNUM !== 8'h06) begin bad++; $display("FAIL bounce_num got=%h exp=06", kif.oKEYNUM); end
        kmap = 16'h0;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_row_held();
        test_reset_mid();
        test_single_key();
        test_bounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
